// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and constants for the register-slave slice.
package axi_lite_pkg;

   localparam int AXI_LITE_STRB_W = 4;
   localparam int AXI_LITE_DATA_W = 32;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [0:0] {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_e;

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_e;

   function automatic logic [1:0] resp_of(input logic err);
      return err ? SLVERR : OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle. Every channel uses valid/ready: a beat transfers on a
// rising edge where both are high; valid, once raised, holds its payload until then.
interface axi_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import axi_lite_pkg::*;

   logic [ADDR_WIDTH-1:0]      awaddr;
   logic                       awvalid;
   logic                       awready;
   logic [DATA_WIDTH-1:0]      wdata;
   logic [AXI_LITE_STRB_W-1:0] wstrb;
   logic                       wvalid;
   logic                       wready;
   logic [1:0]                 bresp;
   logic                       bvalid;
   logic                       bready;
   logic [ADDR_WIDTH-1:0]      araddr;
   logic                       arvalid;
   logic                       arready;
   logic [DATA_WIDTH-1:0]      rdata;
   logic [1:0]                 rresp;
   logic                       rvalid;
   logic                       rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi_lite_reg_array.sv
// Register storage: byte-strobed synchronous write port, asynchronous read port.
module axi_lite_reg_array
   import axi_lite_pkg::*;
#(
   parameter int NUM_REGS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [IDX_W-1:0]           widx,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic [AXI_LITE_STRB_W-1:0] wstrb,
   input  logic [IDX_W-1:0]           ridx,
   output logic [DATA_WIDTH-1:0]      rdata
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < AXI_LITE_STRB_W; b++) begin
            if (wstrb[b]) regs[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Same-edge read sees the pre-write value because the write lands on the edge.
   assign rdata = regs[ridx];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave register bank with independent read and write FSMs.
// Optional out-of-range SLVERR decode: AXI_LITE_REG_SLAVE_RANGE_ERR_EN.
module axi_lite_reg_slave
   import axi_lite_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic       aclk,
   input  logic       areset_n,
   axi_lite_if.slave  s,
   output logic [0:0] dbg_wr_state,
   output logic [0:0] dbg_rd_state
);

   localparam int         IDX_W  = $clog2(NUM_REGS);
   localparam logic [0:0] W_IDLE = WR_IDLE;
   localparam logic [0:0] W_RESP = WR_RESP;
   localparam logic [0:0] R_IDLE = RD_IDLE;
   localparam logic [0:0] R_DATA = RD_DATA;

   logic [0:0]                 w_state, w_state_n;
   logic                       aw_held, aw_held_n, w_held, w_held_n;
   logic [ADDR_WIDTH-1:0]      aw_q, aw_q_n;
   logic [DATA_WIDTH-1:0]      wd_q, wd_q_n;
   logic [AXI_LITE_STRB_W-1:0] ws_q, ws_q_n;
   logic                       awready_n, wready_n, bvalid_n;
   logic [1:0]                 bresp_n;
   logic                       commit;

   logic [0:0]                 r_state, r_state_n;
   logic                       arready_n, rvalid_n;
   logic [DATA_WIDTH-1:0]      rdata_n;
   logic [1:0]                 rresp_n;

   logic [ADDR_WIDTH-1:0]      w_off, r_off;
   logic [IDX_W-1:0]           w_idx, r_idx;
   logic                       wr_err, rd_err;
   logic [DATA_WIDTH-1:0]      arr_rdata;

   assign w_off = aw_q - BASE_ADDR;
   assign r_off = s.araddr - BASE_ADDR;
   assign w_idx = w_off[IDX_W+1:2];
   assign r_idx = r_off[IDX_W+1:2];

`ifdef AXI_LITE_REG_SLAVE_RANGE_ERR_EN
   // Offset below BASE_ADDR wraps to a huge value, so one compare covers both ends.
   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * 4);
   assign wr_err = (w_off >= SPAN);
   assign rd_err = (r_off >= SPAN);
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

   axi_lite_reg_array #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_regs (
      .clk   (aclk),
      .rst_n (areset_n),
      .we    (commit && !wr_err),
      .widx  (w_idx),
      .wdata (wd_q),
      .wstrb (ws_q),
      .ridx  (r_idx),
      .rdata (arr_rdata)
   );

   always_comb begin
      w_state_n = w_state;
      aw_held_n = aw_held;
      w_held_n  = w_held;
      aw_q_n    = aw_q;
      wd_q_n    = wd_q;
      ws_q_n    = ws_q;
      bvalid_n  = s.bvalid;
      bresp_n   = s.bresp;
      commit    = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (s.awvalid && s.awready) begin
               aw_held_n = 1'b1;
               aw_q_n    = s.awaddr;
            end
            if (s.wvalid && s.wready) begin
               w_held_n = 1'b1;
               wd_q_n   = s.wdata;
               ws_q_n   = s.wstrb;
            end
            // Both readys are low while both halves are held, so no capture overlaps a commit.
            if (aw_held && w_held) begin
               commit    = 1'b1;
               w_state_n = W_RESP;
               bvalid_n  = 1'b1;
               bresp_n   = resp_of(wr_err);
               aw_held_n = 1'b0;
               w_held_n  = 1'b0;
            end
         end
         W_RESP: begin
            if (s.bready) begin
               w_state_n = W_IDLE;
               bvalid_n  = 1'b0;
            end
         end
         default: w_state_n = W_IDLE;
      endcase
      awready_n = (w_state_n == W_IDLE) && !aw_held_n;
      wready_n  = (w_state_n == W_IDLE) && !w_held_n;
   end

   always_comb begin
      r_state_n = r_state;
      rvalid_n  = s.rvalid;
      rdata_n   = s.rdata;
      rresp_n   = s.rresp;
      case (r_state)
         R_IDLE: begin
            if (s.arvalid && s.arready) begin
               r_state_n = R_DATA;
               rvalid_n  = 1'b1;
               rdata_n   = rd_err ? '0 : arr_rdata;
               rresp_n   = resp_of(rd_err);
            end
         end
         R_DATA: begin
            if (s.rready) begin
               r_state_n = R_IDLE;
               rvalid_n  = 1'b0;
            end
         end
         default: r_state_n = R_IDLE;
      endcase
      arready_n = (r_state_n == R_IDLE);
   end

   // Readys are registered from next-state so they stay low through reset.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         w_state   <= W_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_q      <= '0;
         wd_q      <= '0;
         ws_q      <= '0;
         s.awready <= 1'b0;
         s.wready  <= 1'b0;
         s.bvalid  <= 1'b0;
         s.bresp   <= OKAY;
         r_state   <= R_IDLE;
         s.arready <= 1'b0;
         s.rvalid  <= 1'b0;
         s.rdata   <= '0;
         s.rresp   <= OKAY;
      end else begin
         w_state   <= w_state_n;
         aw_held   <= aw_held_n;
         w_held    <= w_held_n;
         aw_q      <= aw_q_n;
         wd_q      <= wd_q_n;
         ws_q      <= ws_q_n;
         s.awready <= awready_n;
         s.wready  <= wready_n;
         s.bvalid  <= bvalid_n;
         s.bresp   <= bresp_n;
         r_state   <= r_state_n;
         s.arready <= arready_n;
         s.rvalid  <= rvalid_n;
         s.rdata   <= rdata_n;
         s.rresp   <= rresp_n;
      end
   end

   assign dbg_wr_state = w_state;
   assign dbg_rd_state = r_state;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave: directed timing cases plus randomized traffic.
module tb_axi_lite_reg_slave;

   localparam int          NUM_REGS  = 4;
   localparam logic [31:0] BASE_ADDR = 32'h0;
   localparam int          TIMEOUT   = 200;

   logic       aclk = 1'b0;
   logic       areset_n = 1'b0;
   logic [0:0] dbg_wr_state;
   logic [0:0] dbg_rd_state;

   axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_lite_reg_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR)
   ) dut (
      .aclk         (aclk),
      .areset_n     (areset_n),
      .s            (bus),
      .dbg_wr_state (dbg_wr_state),
      .dbg_rd_state (dbg_rd_state)
   );

   // ---------------- clock / reset ----------------
   always #5 aclk = ~aclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [1:0]  b_exp_q [$];
   logic [33:0] r_exp_q [$];
   logic [31:0] model_regs [NUM_REGS];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_in_range(input logic [31:0] addr);
      longint unsigned a = {32'h0, addr};
      longint unsigned lo = {32'h0, BASE_ADDR};
      return (a >= lo) && (a < lo + NUM_REGS * 4);
   endfunction

   function automatic int model_idx(input logic [31:0] addr);
      longint unsigned off = {32'h0, addr} - {32'h0, BASE_ADDR};
      return int'((off / 4) % NUM_REGS);
   endfunction

   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
      int idx = model_idx(addr);
`ifdef AXI_LITE_REG_SLAVE_RANGE_ERR_EN
      if (!model_in_range(addr)) return 2'b10;
`endif
      for (int b = 0; b < 4; b++)
         if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic logic [33:0] model_read(input logic [31:0] addr);
`ifdef AXI_LITE_REG_SLAVE_RANGE_ERR_EN
      if (!model_in_range(addr)) return {2'b10, 32'h0};
`endif
      return {2'b00, model_regs[model_idx(addr)]};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;
   endfunction

   // ---------------- monitor ----------------
   initial begin
      logic [1:0]  eb;
      logic [33:0] er;
      forever begin
         @(negedge aclk);
         if (areset_n && bus.bvalid && bus.bready) begin
            if (b_exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL b_unexpected: got bresp %0h with empty queue", bus.bresp);
            end else begin
               eb = b_exp_q.pop_front();
               check("bresp", {62'h0, bus.bresp}, {62'h0, eb});
            end
         end
         if (areset_n && bus.rvalid && bus.rready) begin
            if (r_exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL r_unexpected: got rdata %0h with empty queue", bus.rdata);
            end else begin
               er = r_exp_q.pop_front();
               check("rdata", {32'h0, bus.rdata}, {32'h0, er[31:0]});
               check("rresp", {62'h0, bus.rresp}, {62'h0, er[33:32]});
            end
         end
      end
   end

   // ---------------- drivers (all start and end 1 time unit after a rising edge) ----------------
   task automatic drive_aw(input logic [31:0] addr, input int dly);
      int t = 0;
      repeat (dly) begin @(posedge aclk); #1; end
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      do begin @(negedge aclk); t++; end while (!bus.awready && t < TIMEOUT);
      check("aw_accept", {63'h0, bus.awready}, 64'h1);
      @(posedge aclk); #1;
      bus.awvalid = 1'b0;
   endtask

   task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
      int t = 0;
      repeat (dly) begin @(posedge aclk); #1; end
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.wvalid = 1'b1;
      do begin @(negedge aclk); t++; end while (!bus.wready && t < TIMEOUT);
      check("w_accept", {63'h0, bus.wready}, 64'h1);
      @(posedge aclk); #1;
      bus.wvalid = 1'b0;
   endtask

   task automatic drive_ar(input logic [31:0] addr, input int dly);
      int t = 0;
      repeat (dly) begin @(posedge aclk); #1; end
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      do begin @(negedge aclk); t++; end while (!bus.arready && t < TIMEOUT);
      check("ar_accept", {63'h0, bus.arready}, 64'h1);
      @(posedge aclk); #1;
      bus.arvalid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      int t = 0;
      b_exp_q.push_back(model_write(addr, data, strb));
      bus.bready = (b_dly == 0);
      fork
         drive_aw(addr, aw_dly);
         drive_w(data, strb, w_dly);
      join
      do begin @(negedge aclk); t++; end while (!bus.bvalid && t < TIMEOUT);
      check("b_arrives", {63'h0, bus.bvalid}, 64'h1);
      if (!bus.bvalid) begin
         void'(b_exp_q.pop_back());
         @(posedge aclk); #1;
         bus.bready = 1'b0;
         return;
      end
      if (!bus.bready) begin
         repeat (b_dly) @(posedge aclk);
         #1 bus.bready = 1'b1;
      end
      @(posedge aclk); #1;
      bus.bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
      int t = 0;
      r_exp_q.push_back(model_read(addr));
      bus.rready = (r_dly == 0);
      drive_ar(addr, ar_dly);
      while (!bus.rvalid && t < TIMEOUT) begin @(negedge aclk); t++; end
      check("r_arrives", {63'h0, bus.rvalid}, 64'h1);
      if (!bus.rvalid) begin
         void'(r_exp_q.pop_back());
         bus.rready = 1'b0;
         return;
      end
      if (!bus.rready) begin
         repeat (r_dly) @(posedge aclk);
         #1 bus.rready = 1'b1;
      end
      @(posedge aclk); #1;
      bus.rready = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [33:0] exp_r;
      int          t;
      bus.awaddr = '0; bus.awvalid = 1'b0;
      bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      model_reset();

      // Reset values and first-edge ready rise.
      repeat (3) @(posedge aclk);
      #1;
      check("rst_awready", {63'h0, bus.awready}, 64'h0);
      check("rst_wready",  {63'h0, bus.wready},  64'h0);
      check("rst_arready", {63'h0, bus.arready}, 64'h0);
      check("rst_bvalid",  {63'h0, bus.bvalid},  64'h0);
      check("rst_rvalid",  {63'h0, bus.rvalid},  64'h0);
      @(negedge aclk);
      areset_n = 1'b1;
      @(posedge aclk); #1;
      check("rel_awready", {63'h0, bus.awready}, 64'h1);
      check("rel_wready",  {63'h0, bus.wready},  64'h1);
      check("rel_arready", {63'h0, bus.arready}, 64'h1);
      do_read(32'h4, 0, 0);

      // AW at edge 0, W handshake at edge 3: bvalid after edge 4, then 5 stalled cycles.
      b_exp_q.push_back(model_write(32'h8, 32'hDEADBEEF, 4'hF));
      bus.bready  = 1'b0;
      bus.awaddr  = 32'h8;
      bus.awvalid = 1'b1;
      @(negedge aclk);
      check("awready_c0", {63'h0, bus.awready}, 64'h1);
      @(posedge aclk); #1;
      bus.awvalid = 1'b0;
      check("awready_held", {63'h0, bus.awready}, 64'h0);
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      bus.wdata  = 32'hDEADBEEF;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      @(posedge aclk); #1;
      bus.wvalid = 1'b0;
      check("bvalid_c3", {63'h0, bus.bvalid}, 64'h0);
      @(posedge aclk); #1;
      check("bvalid_c4", {63'h0, bus.bvalid}, 64'h1);
      check("bresp_c4",  {62'h0, bus.bresp},  64'h0);
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk); #1;
         check("bstall_bvalid",  {63'h0, bus.bvalid},  64'h1);
         check("bstall_bresp",   {62'h0, bus.bresp},   64'h0);
         check("bstall_awready", {63'h0, bus.awready}, 64'h0);
      end
      bus.bready = 1'b1;
      @(posedge aclk); #1;
      bus.bready = 1'b0;
      check("b_done_bvalid",  {63'h0, bus.bvalid},  64'h0);
      check("b_done_awready", {63'h0, bus.awready}, 64'h1);

      // Read of 0x8 with rready held low for 5 cycles.
      exp_r = model_read(32'h8);
      r_exp_q.push_back(exp_r);
      bus.rready  = 1'b0;
      bus.araddr  = 32'h8;
      bus.arvalid = 1'b1;
      @(posedge aclk); #1;
      bus.arvalid = 1'b0;
      check("rvalid_same_edge", {63'h0, bus.rvalid}, 64'h1);
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk); #1;
         check("rstall_rvalid",  {63'h0, bus.rvalid},  64'h1);
         check("rstall_rdata",   {32'h0, bus.rdata},   {32'h0, exp_r[31:0]});
         check("rstall_rresp",   {62'h0, bus.rresp},   {62'h0, exp_r[33:32]});
         check("rstall_arready", {63'h0, bus.arready}, 64'h0);
      end
      bus.rready = 1'b1;
      @(posedge aclk); #1;
      bus.rready = 1'b0;
      check("r_done_rvalid",  {63'h0, bus.rvalid},  64'h0);
      check("r_done_arready", {63'h0, bus.arready}, 64'h1);

      // Byte strobes: expect 0x11BB33DD.
      do_write(32'h0, 32'h11223344, 4'hF, 0, 0, 0);
      do_write(32'h0, 32'hAABBCCDD, 4'b0101, 1, 0, 2);
      do_read(32'h0, 0, 1);

      // Read handshake on the commit edge returns the pre-write value.
      r_exp_q.push_back(model_read(32'h4));
      b_exp_q.push_back(model_write(32'h4, 32'h5, 4'hF));
      bus.bready  = 1'b1;
      bus.rready  = 1'b1;
      bus.awaddr  = 32'h4; bus.awvalid = 1'b1;
      bus.wdata   = 32'h5; bus.wstrb   = 4'hF; bus.wvalid = 1'b1;
      @(posedge aclk); #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.araddr  = 32'h4;
      bus.arvalid = 1'b1;
      @(posedge aclk); #1;
      bus.arvalid = 1'b0;
      check("commit_bvalid", {63'h0, bus.bvalid}, 64'h1);
      check("commit_rvalid", {63'h0, bus.rvalid}, 64'h1);
      @(posedge aclk); #1;
      bus.bready = 1'b0;
      bus.rready = 1'b0;
      do_read(32'h4, 0, 0);

      // Reset between the AW/W handshake and the commit: no B, array cleared.
      bus.awaddr = 32'hC; bus.awvalid = 1'b1;
      bus.wdata  = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      @(posedge aclk); #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      areset_n    = 1'b0;
      model_reset();
      #1;
      check("midrst_bvalid",  {63'h0, bus.bvalid},  64'h0);
      check("midrst_awready", {63'h0, bus.awready}, 64'h0);
      @(negedge aclk);
      areset_n = 1'b1;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      check("midrst_no_b", {63'h0, bus.bvalid},  64'h0);
      check("midrst_rdy",  {63'h0, bus.awready}, 64'h1);
      do_read(32'hC, 0, 0);
      do_read(32'h8, 0, 0);

      // Out-of-range address 0x10.
      do_write(32'h0, 32'h0000A5A5, 4'hF, 0, 0, 0);
      do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 1, 0);
      do_read(32'h10, 0, 0);
      do_read(32'h0, 0, 0);

      // Randomized traffic, half the addresses beyond the register window.
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         a = $urandom_range(0, NUM_REGS * 8 - 1);
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      t = 0;
      while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && t < TIMEOUT) begin
         @(negedge aclk);
         t++;
      end
      check("b_queue_drained", 64'(b_exp_q.size()), 64'h0);
      check("r_queue_drained", 64'(r_exp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
